// File: rtl/bus_timer_responder.sv
// bus_timer_responder
//   Memory-mapped down-counter timer that answers the Frost32Cpu memory bus.
//   Each access it claims is answered with a fixed wait-state handshake:
//   IDLE -> BUSY -> RESP -> IDLE. The timer drives the CPU interrupt input.
//
//   Register map (offset = bus_addr[4:2]):
//     0 CTRL     [0] enable, [1] irq_en, [2] auto_reload
//     1 COUNT    32-bit down-counter
//     2 RELOAD   32-bit reload value
//     3 STATUS   [0] pending, write-1-to-clear
//     4 PRESCALE [15:0], only when BUS_TIMER_PRESCALER_EN is defined
//     5..7       read as 0, writes ignored
//
//   Optional feature macro: BUS_TIMER_PRESCALER_EN adds the PRESCALE register.
//   Without it the timer ticks on every enabled cycle.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bus_req         CPU access request
//   bus_addr        CPU byte address
//   bus_access_type 0 = read, 1 = write
//   bus_access_size 0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = reserved
//   bus_data_in     write data, right-aligned for sub-word writes
//   bus_data_out    read data, non-zero only in the RESP cycle
//   bus_wait        high while an access is in progress
//   interrupt       registered pending & irq_en
module bus_timer_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic [31:0] bus_addr,
  input  logic        bus_access_type,
  input  logic [1:0]  bus_access_size,
  input  logic [31:0] bus_data_in,
  output logic [31:0] bus_data_out,
  output logic        bus_wait,
  output logic        interrupt
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [2:0]  req_offset;
  logic [1:0]  req_lane;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_data;

  logic        enable, irq_en, auto_reload, pending;
  logic [31:0] count, reload;

  logic        selected, last_wait, commit, tick, tick_eff;
  logic        wr_ctrl, wr_count, wr_reload, wr_status;
  logic [31:0] rd_word, wr_base, wr_word;

`ifdef BUS_TIMER_PRESCALER_EN
  logic [15:0] prescale, presc_cnt;
  logic        wr_presc;
`endif

  // Merge right-aligned write data into the lanes chosen by size and addr[1:0].
  function automatic logic [31:0] merge_write(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = old;
    case (size)
      2'd0: res = data;
      2'd1: if (lane[1]) res[31:16] = data[15:0];
            else         res[15:0]  = data[15:0];
      2'd2: case (lane)
              2'd0: res[7:0]   = data[7:0];
              2'd1: res[15:8]  = data[7:0];
              2'd2: res[23:16] = data[7:0];
              default: res[31:24] = data[7:0];
            endcase
      default: res = old;
    endcase
    return res;
  endfunction

  // Reserved-size requests are treated like requests outside the window.
  assign selected  = bus_req && (bus_addr[31:5] == BASE_ADDR[31:5]) &&
                     (bus_access_size != 2'd3);
  assign last_wait = (state == BUSY) && (wait_cnt == 4'd0);
  assign commit    = last_wait && req_write;
  assign wr_ctrl   = commit && (req_offset == 3'd0);
  assign wr_count  = commit && (req_offset == 3'd1);
  assign wr_reload = commit && (req_offset == 3'd2);
  assign wr_status = commit && (req_offset == 3'd3);

  // Register read mux for the captured offset; also the base for sub-word merges.
  always_comb begin
    rd_word = 32'h0;
    case (req_offset)
      3'd0: rd_word = {29'h0, auto_reload, irq_en, enable};
      3'd1: rd_word = count;
      3'd2: rd_word = reload;
      3'd3: rd_word = {31'h0, pending};
`ifdef BUS_TIMER_PRESCALER_EN
      3'd4: rd_word = {16'h0, prescale};
`endif
      default: rd_word = 32'h0;
    endcase
  end

  // STATUS merges onto zero so only bits actually written can clear pending.
  assign wr_base = (req_offset == 3'd3) ? 32'h0 : rd_word;
  assign wr_word = merge_write(wr_base, req_data, req_size, req_lane);

`ifdef BUS_TIMER_PRESCALER_EN
  assign wr_presc = commit && (req_offset == 3'd4);
  assign tick     = enable && (presc_cnt == prescale);
`else
  assign tick     = enable;
`endif

  // A bus write to COUNT or CTRL on a tick edge swallows that tick.
  assign tick_eff = tick && !(wr_ctrl || wr_count);

  // Bus handshake FSM with registered bus_wait and bus_data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      req_offset   <= 3'd0;
      req_lane     <= 2'd0;
      req_write    <= 1'b0;
      req_size     <= 2'd0;
      req_data     <= 32'h0;
      bus_wait     <= 1'b0;
      bus_data_out <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          bus_data_out <= 32'h0;
          if (selected) begin
            req_offset <= bus_addr[4:2];
            req_lane   <= bus_addr[1:0];
            req_write  <= bus_access_type;
            req_size   <= bus_access_size;
            req_data   <= bus_data_in;
            bus_wait   <= 1'b1;
            wait_cnt   <= WAIT_INIT;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt == 4'd0) begin
            bus_wait     <= 1'b0;
            bus_data_out <= req_write ? 32'h0 : rd_word;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          bus_data_out <= 32'h0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Timer registers: bus writes, tick handling and the interrupt register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      pending     <= 1'b0;
      count       <= 32'h0;
      reload      <= 32'h0;
      interrupt   <= 1'b0;
    end else begin
      if (wr_ctrl)
        {auto_reload, irq_en, enable} <= wr_word[2:0];
      else if (tick_eff && (count == 32'h0) && !auto_reload)
        enable <= 1'b0;

      if (wr_count)
        count <= wr_word;
      else if (tick_eff)
        count <= (count != 32'h0) ? count - 32'd1 : (auto_reload ? reload : 32'h0);

      if (wr_reload)
        reload <= wr_word;

      // A pending set beats a simultaneous write-1-to-clear.
      if (tick_eff && (count == 32'h0))
        pending <= 1'b1;
      else if (wr_status && wr_word[0])
        pending <= 1'b0;

      interrupt <= pending & irq_en;
    end
  end

`ifdef BUS_TIMER_PRESCALER_EN
  // Prescaler: one tick every prescale+1 enabled cycles, restarted on disable or rewrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale  <= 16'h0;
      presc_cnt <= 16'h0;
    end else begin
      if (wr_presc)
        prescale <= wr_word[15:0];
      if (!enable || wr_presc || tick)
        presc_cnt <= 16'h0;
      else
        presc_cnt <= presc_cnt + 16'd1;
    end
  end
`endif

endmodule
